pwm_duty_meter: RTL and testbench

Receive-side counterpart to the PWM generator: samples an external PWM line and reports its period, its high time, and its duty cycle in integer percent.
Used as an in-system monitor for motor-drive PWM such as MG33, and as a self-checking sink in generator loopback benches.

---
 rtl/pwm_meter_pkg.sv | 13 +
 rtl/seq_divider.sv | 70 +++++++
 rtl/pwm_duty_meter.sv | 148 ++++++++++++++
 tb/tb_pwm_duty_meter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_meter_pkg.sv
// Shared types and constants for the PWM duty-cycle meter.
package pwm_meter_pkg;

  typedef enum logic [1:0] {
    StArm,
    StMeasure,
    StDivide
  } meter_st_e;

  localparam int unsigned PCT_SCALE = 100;
  localparam int unsigned DUTY_W    = 7;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// The first bit is resolved on the start edge, so done pulses W-1 cycles after start.
module seq_divider #(
  parameter int unsigned W = 23
) (
  input  logic         Clk_i,
  input  logic         Reset_i,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int unsigned CntW = $clog2(W + 1);

  logic [W-1:0]    rem_q, quo_q, div_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q, done_q;

  logic [W-1:0] rem_src, quo_src, div_src, rem_nxt, quo_nxt;
  logic [W:0]   shift, diff;
  logic         qbit;

  always_comb begin
    rem_src = start ? '0 : rem_q;
    quo_src = start ? dividend : quo_q;
    div_src = start ? divisor : div_q;
    shift   = {rem_src, quo_src[W-1]};
    diff    = shift - {1'b0, div_src};
    // A borrow into the top bit means the trial subtraction went negative.
    qbit    = ~diff[W];
    rem_nxt = qbit ? diff[W-1:0] : shift[W-1:0];
    quo_nxt = {quo_src[W-2:0], qbit};
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q  <= rem_nxt;
        quo_q  <= quo_nxt;
        div_q  <= divisor;
        cnt_q  <= CntW'(W - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period, high time and integer duty percentage of an asynchronous PWM line.
// Reports on every accepted rise, or on a no-edge timeout as a 0 % / 100 % level report.
module pwm_duty_meter
  import pwm_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              Clk_i,
  input  logic              Reset_i,
  input  logic              Pwm_i,
  output logic [DUTY_W-1:0] Duty_o,
  output logic [CNT_W-1:0]  Period_o,
  output logic [CNT_W-1:0]  High_o,
  output logic              Valid_o,
  output logic              Timeout_o,
  output logic              Overrun_o
);

  localparam int unsigned      DivW   = CNT_W + DUTY_W;
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] TmoVal = CNT_W'(TIMEOUT_CYC);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl, lvl_d_q, rise, tmo_fire, accept;
  logic [CNT_W-1:0]       per_cnt_q, hi_cnt_q, p_q, h_q;
  logic [CNT_W-1:0]       period_q, high_q;
  logic [DUTY_W-1:0]      duty_q;
  logic                   valid_q, tmo_q, ovr_q;
  meter_st_e              state_q;

  logic            div_busy, div_done;
  logic [DivW-1:0] div_dividend, div_divisor, div_quo;
  logic            unused_quo_hi;

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~lvl_d_q;
  // A rise always wins over a timeout; a timeout is held off until a division reports.
  assign tmo_fire = (per_cnt_q >= TmoVal) && !rise && (state_q != StDivide);
  assign accept   = rise && (state_q == StMeasure) && !div_busy;

  assign div_dividend  = DivW'(hi_cnt_q) * DivW'(PCT_SCALE);
  assign div_divisor   = DivW'(per_cnt_q);
  assign unused_quo_hi = ^div_quo[DivW-1:DUTY_W];

  seq_divider #(
    .W(DivW)
  ) u_div (
    .Clk_i   (Clk_i),
    .Reset_i (Reset_i),
    .start   (accept),
    .dividend(div_dividend),
    .divisor (div_divisor),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quo)
  );

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      sync_q    <= '0;
      lvl_d_q   <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      p_q       <= '0;
      h_q       <= '0;
      period_q  <= '0;
      high_q    <= '0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      tmo_q     <= 1'b0;
      ovr_q     <= 1'b0;
      state_q   <= StArm;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], Pwm_i};
      lvl_d_q <= lvl;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;

      if (rise) begin
        per_cnt_q <= CNT_W'(1);
        hi_cnt_q  <= CNT_W'(1);
      end else begin
        if (tmo_fire) begin
          per_cnt_q <= '0;
        end else if (per_cnt_q != CntMax) begin
          per_cnt_q <= per_cnt_q + 1'b1;
        end
        if (lvl && (hi_cnt_q != CntMax)) begin
          hi_cnt_q <= hi_cnt_q + 1'b1;
        end
      end

      if (tmo_fire) begin
        valid_q  <= 1'b1;
        duty_q   <= lvl ? DUTY_W'(PCT_SCALE) : '0;
        period_q <= '0;
        high_q   <= '0;
        tmo_q    <= 1'b1;
      end

      case (state_q)
        StArm: begin
          if (rise) begin
            state_q <= StMeasure;
          end
        end
        StMeasure: begin
          if (accept) begin
            p_q     <= per_cnt_q;
            h_q     <= hi_cnt_q;
            state_q <= StDivide;
          end else if (rise) begin
            ovr_q <= 1'b1;
          end else if (tmo_fire) begin
            state_q <= StArm;
          end
        end
        StDivide: begin
          if (rise) begin
            ovr_q <= 1'b1;
          end
          if (div_done) begin
            valid_q  <= 1'b1;
            duty_q   <= div_quo[DUTY_W-1:0];
            period_q <= p_q;
            high_q   <= h_q;
            tmo_q    <= 1'b0;
          end
          // Stay busy through the report cycle so a rise there is still an overrun.
          if (valid_q) begin
            state_q <= StMeasure;
          end
        end
        default: state_q <= StArm;
      endcase
    end
  end

  assign Duty_o    = duty_q;
  assign Period_o  = period_q;
  assign High_o    = high_q;
  assign Valid_o   = valid_q;
  assign Timeout_o = tmo_q;
  assign Overrun_o = ovr_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Randomised scoreboard bench for pwm_duty_meter against a cycle-indexed reference model.
module tb_pwm_duty_meter;

  localparam int CNT_W = 16;
  localparam int TMO   = 300;
  localparam int SYNC  = 2;
  localparam int LAT   = CNT_W + 8;
  localparam int QSZ   = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm = 1'b0;
  logic [6:0]  duty;
  logic [15:0] period, high;
  logic        valid, tmo, ovr;

  always #5 clk = ~clk;

  pwm_duty_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TMO),
    .SYNC_STAGES(SYNC)
  ) dut (
    .Clk_i    (clk),
    .Reset_i  (rst),
    .Pwm_i    (pwm),
    .Duty_o   (duty),
    .Period_o (period),
    .High_o   (high),
    .Valid_o  (valid),
    .Timeout_o(tmo),
    .Overrun_o(ovr)
  );

  // Expected reports and overrun pulses, indexed by the cycle they must appear in.
  int e_cyc [QSZ];
  int e_duty[QSZ];
  int e_per [QSZ];
  int e_hi  [QSZ];
  bit e_tmo [QSZ];
  int o_cyc [QSZ];
  int exp_wr = 0, ovr_wr = 0, flush_e = 0, flush_o = 0;

  bit inh[0:65535];
  int cyc = 0, rst_cyc = 0, z = 0, last_rise = 0, busy_until = 0;
  bit rst_s = 1'b0, armed = 1'b0, stim_done = 1'b0;

  int checks = 0, passes = 0;

  function automatic bit lvl_at(int x);
    if (x - SYNC + 1 > rst_cyc) return inh[x-SYNC+1];
    return 1'b0;
  endfunction

  task automatic push_rep(input int c, input int d, input int p, input int h, input bit t);
    e_cyc[exp_wr % QSZ]  = c;
    e_duty[exp_wr % QSZ] = d;
    e_per[exp_wr % QSZ]  = p;
    e_hi[exp_wr % QSZ]   = h;
    e_tmo[exp_wr % QSZ]  = t;
    exp_wr++;
  endtask

  // Apply the measurement rules to the synchronised line level of cycle p.
  task automatic step(input int p);
    bit lv, lp;
    int h, per;
    lv = lvl_at(p);
    lp = lvl_at(p - 1);
    if (lv && !lp) begin
      if (!armed) begin
        armed = 1'b1;
      end else if (p <= busy_until) begin
        o_cyc[ovr_wr % QSZ] = p + 1;
        ovr_wr++;
      end else begin
        per = p - last_rise;
        h   = 0;
        for (int x = last_rise; x < p; x++) h += int'(lvl_at(x));
        push_rep(p + LAT, (h * 100) / per, per, h, 1'b0);
        busy_until = p + LAT;
      end
      last_rise = p;
      z = p;
    end else if ((p - z >= TMO) && (p > busy_until)) begin
      push_rep(p + 1, lv ? 100 : 0, 0, 0, 1'b1);
      armed = 1'b0;
      z = p + 1;
    end
  endtask

  always @(posedge clk) begin : model
    cyc = cyc + 1;
    if (!rst_s && cyc > 1) step(cyc - 1);
    if (cyc < 65536) inh[cyc] = pwm;
    rst_s = rst;
    if (rst) begin
      rst_cyc    = cyc;
      z          = cyc;
      armed      = 1'b0;
      busy_until = 0;
      flush_e    = exp_wr;
      flush_o    = ovr_wr;
    end
  end

  initial begin : monitor
    int rd_e, rd_o, i;
    rd_e = 0;
    rd_o = 0;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        if (rst_s) begin
          checks++;
          if (valid || ovr || tmo || duty != 0 || period != 0 || high != 0)
            $display("FAIL reset_state cyc=%0d: got v=%b o=%b t=%b d=%0d p=%0d h=%0d want all 0",
                     cyc, valid, ovr, tmo, duty, period, high);
          else passes++;
        end else begin
          if (rd_e < flush_e) rd_e = flush_e;
          if (rd_o < flush_o) rd_o = flush_o;
          if (valid) begin
            checks++;
            if (rd_e == exp_wr) begin
              $display("FAIL unexpected_valid cyc=%0d: got d=%0d p=%0d h=%0d t=%b want none",
                       cyc, duty, period, high, tmo);
            end else begin
              i = rd_e % QSZ;
              if (e_cyc[i] != cyc || e_duty[i] != int'(duty) || e_per[i] != int'(period) ||
                  e_hi[i] != int'(high) || e_tmo[i] != tmo)
                $display("FAIL report: got cyc=%0d d=%0d p=%0d h=%0d t=%b want cyc=%0d d=%0d p=%0d h=%0d t=%b",
                         cyc, duty, period, high, tmo,
                         e_cyc[i], e_duty[i], e_per[i], e_hi[i], e_tmo[i]);
              else passes++;
              rd_e++;
            end
          end else if (rd_e < exp_wr && e_cyc[rd_e % QSZ] <= cyc) begin
            checks++;
            $display("FAIL missing_valid: got none by cyc=%0d want report at cyc=%0d d=%0d",
                     cyc, e_cyc[rd_e % QSZ], e_duty[rd_e % QSZ]);
            rd_e++;
          end
          if (ovr) begin
            checks++;
            if (rd_o == ovr_wr) begin
              $display("FAIL unexpected_overrun: got pulse at cyc=%0d want none", cyc);
            end else begin
              if (o_cyc[rd_o % QSZ] != cyc)
                $display("FAIL overrun: got cyc=%0d want cyc=%0d", cyc, o_cyc[rd_o % QSZ]);
              else passes++;
              rd_o++;
            end
          end else if (rd_o < ovr_wr && o_cyc[rd_o % QSZ] <= cyc) begin
            checks++;
            $display("FAIL missing_overrun: got none by cyc=%0d want cyc=%0d",
                     cyc, o_cyc[rd_o % QSZ]);
            rd_o++;
          end
        end
      end
      if (stim_done || cyc > 60000) begin
        checks++;
        if (rd_e != exp_wr || rd_o != ovr_wr || !stim_done)
          $display("FAIL drain: got %0d reports %0d overruns pending, done=%b want 0 0 1",
                   exp_wr - rd_e, ovr_wr - rd_o, stim_done);
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
      end
    end
  end

  task automatic seg(input bit level, input int n);
    pwm = level;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++) begin
      seg(1'b1, hi);
      seg(1'b0, per - hi);
    end
  endtask

  initial begin : stim
    int per, hi;
    rst = 1'b1;
    pwm = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    seg(1'b0, 700);               // static low: timeouts reporting 0 %
    pulses(100, 20, 6);
    pulses(100, 50, 5);
    seg(1'b1, 700);               // static high: timeouts reporting 100 %
    seg(1'b0, 40);
    pulses(30, 10, 6);            // truncates to 33
    pulses(10, 5, 12);            // faster than the divider: overruns
    seg(1'b0, 40);
    pulses(25, 12, 5);            // shortest period without overrun
    pulses(24, 7, 5);             // one cycle too short
    for (int k = 0; k < 25; k++) begin
      per = $urandom_range(250, 8);
      hi  = $urandom_range(per - 1, 1);
      pulses(per, hi, 1);
    end
    seg(1'b0, 60);
    pulses(60, 30, 1);
    pwm = 1'b1;
    repeat (12) @(negedge clk);   // reset lands mid-division
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    seg(1'b0, 30);
    pulses(60, 30, 4);
    for (int k = 0; k < 10; k++) begin
      per = $urandom_range(120, 26);
      hi  = $urandom_range(per, 1);
      pulses(per, hi, 1);
    end
    seg(1'b0, 60);
    stim_done = 1'b1;
  end

endmodule
